// File: rtl/biriscv_csr_dbg_arb.sv
// CSR write-port / debug-read arbiter: core writebacks pass straight through, and debug
// requests are captured and granted on the first free cycle. Optional starvation guard: BIRISCV_CSR_DBG_STARVE_EN.
module biriscv_csr_dbg_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_write_i,
  input  logic [11:0] wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [11:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic        dbg_err_o,
  output logic [31:0] dbg_rdata_o,
  output logic        csr_write_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic [11:0] csr_raddr_o,
  input  logic [31:0] csr_rdata_i,
  output logic        core_stall_o
);

  // state    | meaning
  // IDLE     | no debug access outstanding
  // ARB      | request captured, waiting for a cycle without a core write
  // RESP     | ack pulse with the registered response
  // WAIT_LOW | waiting for the requester to drop dbg_req_i
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_RESP, S_WAIT_LOW} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        w_capture;
  logic        w_grant;
  logic        w_ro;
  logic        w_dbg_wr_grant;

  assign w_capture      = (r_state == S_IDLE) && dbg_req_i;
  assign w_grant        = (r_state == S_ARB) && !wb_write_i;
  assign w_ro           = (r_addr[11:10] == 2'b11);
  assign w_dbg_wr_grant = w_grant && r_we && !w_ro;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (dbg_req_i) w_state_nxt = S_ARB;
      S_ARB:      if (!wb_write_i) w_state_nxt = S_RESP;
      S_RESP:     w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: if (!dbg_req_i) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dbg_ack_o   = 1'b0;
    dbg_err_o   = 1'b0;
    dbg_rdata_o = '0;
    if (r_state == S_RESP) begin
      dbg_ack_o   = 1'b1;
      dbg_err_o   = r_err;
      dbg_rdata_o = r_rdata;
    end
    csr_write_o = wb_write_i | w_dbg_wr_grant;
    csr_waddr_o = '0;
    csr_wdata_o = wb_wdata_i;
    if (wb_write_i) begin
      csr_waddr_o = wb_waddr_i;
    end else if (w_dbg_wr_grant) begin
      csr_waddr_o = r_addr;
      csr_wdata_o = r_wdata;
    end
  end

  assign csr_raddr_o = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_we    <= dbg_we_i;
      r_addr  <= dbg_addr_i;
      r_wdata <= dbg_wdata_i;
    end
  end

  // Read data is sampled at the grant edge, so a core write one cycle earlier is already visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_grant) begin
      r_err   <= r_we && w_ro;
      r_rdata <= r_we ? '0 : csr_rdata_i;
    end
  end

`ifdef BIRISCV_CSR_DBG_STARVE_EN
  localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] r_starve_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_stall;

  always_comb begin
    w_cnt_nxt = r_starve_cnt;
    if (w_capture)
      w_cnt_nxt = '0;
    else if ((r_state == S_ARB) && wb_write_i && (r_starve_cnt != 8'hFF))
      w_cnt_nxt = r_starve_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      r_starve_cnt <= w_cnt_nxt;
      r_stall      <= (w_state_nxt == S_ARB) && (w_cnt_nxt >= LP_LIMIT);
    end
  end

  assign core_stall_o = r_stall;
`else
  logic w_unused_limit;
  assign w_unused_limit = ^STARVE_LIMIT;
  assign core_stall_o   = 1'b0;
`endif

endmodule

// File: tb/tb_biriscv_csr_dbg_arb.sv
// Directed-vector bench for biriscv_csr_dbg_arb; inputs change just after the falling edge
// and outputs are checked 1 time unit later.
module tb_biriscv_csr_dbg_arb;

`ifdef BIRISCV_CSR_DBG_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_write_i;
  logic [11:0] wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [11:0] dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_ack_o;
  logic        dbg_err_o;
  logic [31:0] dbg_rdata_o;
  logic        csr_write_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [11:0] csr_raddr_o;
  logic [31:0] csr_rdata_i;
  logic        core_stall_o;
  logic [31:0] rd_300;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Regfile stand-in: 0x300 returns a settable value, every other address reads back its own address.
  assign csr_rdata_i = (csr_raddr_o == 12'h300) ? rd_300 : {20'h0, csr_raddr_o};

  biriscv_csr_dbg_arb #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_write_i(wb_write_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_ack_o(dbg_ack_o), .dbg_err_o(dbg_err_o), .dbg_rdata_o(dbg_rdata_o),
    .csr_write_o(csr_write_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i), .core_stall_o(core_stall_o)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [11:0] a, input logic [31:0] d);
    dbg_req_i = req; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
  endtask

  task automatic set_wb(input logic w, input logic [11:0] a, input logic [31:0] d);
    wb_write_i = w; wb_waddr_i = a; wb_wdata_i = d;
  endtask

  task automatic test_reset();
    logic [125:0] outs;
    rst_n = 1'b0; rd_300 = 32'h0000_1800;
    set_wb(1'b0, 12'h0, 32'h0); set_dbg(1'b0, 1'b0, 12'h0, 32'h0);
    step(); step(); #1;
    outs = {dbg_ack_o, dbg_err_o, dbg_rdata_o, csr_write_o, csr_waddr_o, csr_wdata_o, csr_raddr_o, core_stall_o};
    n_total++; if (outs !== '0) $display("FAIL reset_outputs got=%h exp=0", outs); else n_pass++;
    step(); rst_n = 1'b1;
    step(); #1;
    n_total++; if ({dbg_ack_o, csr_write_o} !== 2'b00) $display("FAIL post_reset_idle got=%b exp=00", {dbg_ack_o, csr_write_o}); else n_pass++;
  endtask

  task automatic test_idle_read();
    step(); set_dbg(1'b1, 1'b0, 12'h300, 32'h0); #1;
    n_total++; if (csr_write_o !== 1'b0) $display("FAIL rd_idle_nowrite got=%b exp=0", csr_write_o); else n_pass++;
    step(); #1;
    n_total++; if ({dbg_ack_o, csr_write_o} !== 2'b00) $display("FAIL rd_grant_noack got=%b exp=00", {dbg_ack_o, csr_write_o}); else n_pass++;
    n_total++; if (csr_raddr_o !== 12'h300) $display("FAIL rd_raddr got=%h exp=300", csr_raddr_o); else n_pass++;
    step(); #1;
    n_total++; if ({dbg_ack_o, dbg_err_o, csr_write_o} !== 3'b100) $display("FAIL rd_ack got=%b exp=100", {dbg_ack_o, dbg_err_o, csr_write_o}); else n_pass++;
    n_total++; if (dbg_rdata_o !== 32'h0000_1800) $display("FAIL rd_data got=%h exp=00001800", dbg_rdata_o); else n_pass++;
    dbg_req_i = 1'b0;
    step(); #1;
    n_total++; if ({dbg_ack_o, dbg_rdata_o} !== 33'h0) $display("FAIL rd_ack_once got=%h exp=0", {dbg_ack_o, dbg_rdata_o}); else n_pass++;
    step();
  endtask

  task automatic test_contended_write();
    step(); set_dbg(1'b1, 1'b1, 12'h341, 32'h8000_0040); set_wb(1'b1, 12'h342, 32'h0000_000B);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      n_total++;
      if ({csr_write_o, csr_waddr_o, csr_wdata_o, dbg_ack_o} !== {1'b1, 12'h342, 32'h0000_000B, 1'b0})
        $display("FAIL cw_passthru_%0d got=%b/%h/%h/%b exp=1/342/0000000b/0", i, csr_write_o, csr_waddr_o, csr_wdata_o, dbg_ack_o);
      else n_pass++;
    end
    step(); set_wb(1'b0, 12'h0, 32'h0000_0055); #1;
    n_total++;
    if ({csr_write_o, csr_waddr_o, csr_wdata_o, dbg_ack_o} !== {1'b1, 12'h341, 32'h8000_0040, 1'b0})
      $display("FAIL cw_dbg_write got=%b/%h/%h/%b exp=1/341/80000040/0", csr_write_o, csr_waddr_o, csr_wdata_o, dbg_ack_o);
    else n_pass++;
    step(); #1;
    n_total++; if ({dbg_ack_o, dbg_err_o, dbg_rdata_o} !== {2'b10, 32'h0}) $display("FAIL cw_ack got=%b/%b/%h exp=1/0/0", dbg_ack_o, dbg_err_o, dbg_rdata_o); else n_pass++;
    n_total++;
    if ({csr_write_o, csr_waddr_o, csr_wdata_o} !== {1'b0, 12'h0, 32'h0000_0055})
      $display("FAIL cw_idle_mux got=%b/%h/%h exp=0/000/00000055", csr_write_o, csr_waddr_o, csr_wdata_o);
    else n_pass++;
    dbg_req_i = 1'b0; wb_wdata_i = 32'h0;
    step(); step();
  endtask

  task automatic test_readonly_write();
    step(); set_dbg(1'b1, 1'b1, 12'hF14, 32'h0000_1234);
    step(); #1;
    n_total++; if (csr_write_o !== 1'b0) $display("FAIL ro_nowrite got=%b exp=0", csr_write_o); else n_pass++;
    step(); #1;
    n_total++;
    if ({dbg_ack_o, dbg_err_o, dbg_rdata_o, csr_write_o} !== {2'b11, 32'h0, 1'b0})
      $display("FAIL ro_ack got=%b/%b/%h/%b exp=1/1/0/0", dbg_ack_o, dbg_err_o, dbg_rdata_o, csr_write_o);
    else n_pass++;
    dbg_req_i = 1'b0;
    step(); step();
  endtask

  task automatic test_starvation();
    logic exp_stall;
    step(); set_dbg(1'b1, 1'b0, 12'h300, 32'h0); set_wb(1'b1, 12'h7C0, 32'h0000_0001);
    for (int i = 1; i <= 10; i++) begin
      step(); #1;
      exp_stall = STARVE_EN && (i >= 9);
      n_total++;
      if ({core_stall_o, dbg_ack_o, csr_write_o, csr_waddr_o} !== {exp_stall, 1'b0, 1'b1, 12'h7C0})
        $display("FAIL starve_blk_%0d got=%b/%b/%b/%h exp=%b/0/1/7c0", i, core_stall_o, dbg_ack_o, csr_write_o, csr_waddr_o, exp_stall);
      else n_pass++;
    end
    step(); set_wb(1'b0, 12'h0, 32'h0); rd_300 = 32'h0000_1880; #1;
    n_total++; if ({dbg_ack_o, csr_write_o} !== 2'b00) $display("FAIL starve_grant got=%b exp=00", {dbg_ack_o, csr_write_o}); else n_pass++;
    step(); #1;
    n_total++;
    if ({dbg_ack_o, dbg_rdata_o, core_stall_o} !== {1'b1, 32'h0000_1880, 1'b0})
      $display("FAIL starve_ack got=%b/%h/%b exp=1/00001880/0", dbg_ack_o, dbg_rdata_o, core_stall_o);
    else n_pass++;
    dbg_req_i = 1'b0; rd_300 = 32'h0000_1800;
    step(); step();
  endtask

  task automatic test_handshake();
    int acks = 0;
    step(); set_dbg(1'b1, 1'b1, 12'h305, 32'h0000_0100);
    step(); #1;
    n_total++;
    if ({csr_write_o, csr_waddr_o, csr_wdata_o} !== {1'b1, 12'h305, 32'h0000_0100})
      $display("FAIL hs_write got=%b/%h/%h exp=1/305/00000100", csr_write_o, csr_waddr_o, csr_wdata_o);
    else n_pass++;
    step(); #1;
    if (dbg_ack_o === 1'b1) acks++;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      if (dbg_ack_o === 1'b1) acks++;
      n_total++; if (csr_write_o !== 1'b0) $display("FAIL hs_held_write_%0d got=%b exp=0", i, csr_write_o); else n_pass++;
    end
    n_total++; if (acks !== 1) $display("FAIL hs_ack_count got=%0d exp=1", acks); else n_pass++;
    step(); dbg_req_i = 1'b0;
    step(); set_dbg(1'b1, 1'b0, 12'h123, 32'h0);
    step(); #1;
    n_total++; if ({dbg_ack_o, csr_raddr_o} !== {1'b0, 12'h123}) $display("FAIL hs_new_grant got=%b/%h exp=0/123", dbg_ack_o, csr_raddr_o); else n_pass++;
    step(); #1;
    n_total++; if ({dbg_ack_o, dbg_rdata_o} !== {1'b1, 32'h0000_0123}) $display("FAIL hs_new_ack got=%b/%h exp=1/00000123", dbg_ack_o, dbg_rdata_o); else n_pass++;
    dbg_req_i = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid_arb();
    logic [125:0] outs;
    int acks = 0;
    step(); set_dbg(1'b1, 1'b1, 12'h341, 32'h0000_0001); set_wb(1'b1, 12'h342, 32'h0000_0002);
    step(); step(); #1;
    rst_n = 1'b0; set_wb(1'b0, 12'h0, 32'h0); set_dbg(1'b0, 1'b0, 12'h0, 32'h0); #1;
    outs = {dbg_ack_o, dbg_err_o, dbg_rdata_o, csr_write_o, csr_waddr_o, csr_wdata_o, csr_raddr_o, core_stall_o};
    n_total++; if (outs !== '0) $display("FAIL rst_mid_outputs got=%h exp=0", outs); else n_pass++;
    step(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      if (dbg_ack_o === 1'b1 || csr_write_o === 1'b1) acks++;
    end
    n_total++; if (acks !== 0) $display("FAIL rst_mid_no_ack got=%0d exp=0", acks); else n_pass++;
    step(); set_dbg(1'b1, 1'b0, 12'h300, 32'h0);
    step(); step(); #1;
    n_total++; if ({dbg_ack_o, dbg_rdata_o} !== {1'b1, 32'h0000_1800}) $display("FAIL rst_mid_reissue got=%b/%h exp=1/00001800", dbg_ack_o, dbg_rdata_o); else n_pass++;
    dbg_req_i = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_contended_write();
    test_readonly_write();
    test_starvation();
    test_handshake();
    test_reset_mid_arb();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
